// File: rtl/wb_trace_buffer_pkg.sv
// Shared definitions for the write-back trace buffer: entry layout and counter widths.
// The entry width and the seq field depend on the WB_TRACE_SEQ_EN macro.
package wb_trace_buffer_pkg;

    localparam int TRACE_XLEN       = 32;
    localparam int TRACE_OVF_CNT_WD = 16;
    localparam int TRACE_SEQ_WD     = 16;

    typedef logic [TRACE_OVF_CNT_WD-1:0] ovf_cnt_t;
    typedef logic [TRACE_SEQ_WD-1:0]     trace_seq_t;

    // Entry layout (LSB first): wdata, pc, waddr[4:0], we[3:0], optional seq[15:0]
    function automatic int trace_entry_wd(input int xlen);
`ifdef WB_TRACE_SEQ_EN
        return 2 * xlen + 9 + TRACE_SEQ_WD;
`else
        return 2 * xlen + 9;
`endif
    endfunction

    localparam int TRACE_WDATA_LSB = 0;
    localparam int TRACE_PC_LSB    = TRACE_XLEN;
    localparam int TRACE_WADDR_LSB = 2 * TRACE_XLEN;
    localparam int TRACE_WE_LSB    = 2 * TRACE_XLEN + 5;
    localparam int TRACE_SEQ_LSB   = 2 * TRACE_XLEN + 9;
    localparam int TRACE_ENTRY_WD  = trace_entry_wd(TRACE_XLEN);

endpackage

// File: rtl/trace_fifo.sv
// Generic first-word-fall-through FIFO with registered occupancy count.
// A push while full is accepted when a pop frees the head slot in the same cycle.
module trace_fifo #(
    parameter int WIDTH = 73,
    parameter int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0] wr_ptr;
    logic [CNT_W-1:0] rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (count == CNT_W'(DEPTH));
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    // Empty drives zeros so a reset or drained buffer never shows stale storage
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + CNT_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + CNT_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_trace_buffer.sv
// Captures retiring register writes from the core's write-back debug port into a
// drainable FIFO, counting drops when full. Optional seq numbering: WB_TRACE_SEQ_EN.
module wb_trace_buffer
    import wb_trace_buffer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int XLEN  = 32,
    localparam int ENTRY_WD = trace_entry_wd(XLEN),
    localparam int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [XLEN-1:0]             debug_wb_pc,
    input  logic [3:0]                  debug_wb_rf_we,
    input  logic [4:0]                  debug_wb_rf_waddr,
    input  logic [XLEN-1:0]             debug_wb_rf_wdata,
    input  logic                        trace_en,
    input  logic                        clr_ovf,
    output logic                        trace_valid,
    input  logic                        trace_ready,
    output logic [ENTRY_WD-1:0]         trace_data,
    output logic [CNT_W-1:0]            trace_count,
    output logic                        trace_ovf,
    output logic [TRACE_OVF_CNT_WD-1:0] ovf_cnt
);

    logic                capture;
    logic                drop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [ENTRY_WD-1:0] entry;

    function automatic ovf_cnt_t sat_inc(input ovf_cnt_t v);
        return (v == '1) ? v : v + ovf_cnt_t'(1);
    endfunction

    assign capture = trace_en && (|debug_wb_rf_we) && (debug_wb_rf_waddr != 5'd0);
    // Full with the sink accepting means the head pops and frees a slot this cycle
    assign drop    = capture && fifo_full && !trace_ready;

`ifdef WB_TRACE_SEQ_EN
    trace_seq_t seq;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seq <= '0;
        end else if (capture) begin
            seq <= seq + trace_seq_t'(1);
        end
    end

    assign entry = {seq, debug_wb_rf_we, debug_wb_rf_waddr, debug_wb_pc, debug_wb_rf_wdata};
`else
    assign entry = {debug_wb_rf_we, debug_wb_rf_waddr, debug_wb_pc, debug_wb_rf_wdata};
`endif

    trace_fifo #(
        .WIDTH (ENTRY_WD),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (capture),
        .pop     (trace_ready),
        .wr_data (entry),
        .rd_data (trace_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (trace_count)
    );

    assign trace_valid = !fifo_empty;

    // Clear takes priority over a coincident drop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trace_ovf <= 1'b0;
            ovf_cnt   <= '0;
        end else if (clr_ovf) begin
            trace_ovf <= 1'b0;
            ovf_cnt   <= '0;
        end else if (drop) begin
            trace_ovf <= 1'b1;
            ovf_cnt   <= sat_inc(ovf_cnt);
        end
    end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Scoreboard bench for wb_trace_buffer: stimulus queues expected entries, a monitor
// compares each accepted output beat. Works with or without WB_TRACE_SEQ_EN.
module tb_wb_trace_buffer;
    import wb_trace_buffer_pkg::*;

    localparam int DEPTH = 16;
    localparam int XLEN  = 32;
    localparam int EW    = trace_entry_wd(XLEN);
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [XLEN-1:0] debug_wb_pc = '0;
    logic [3:0]      debug_wb_rf_we = '0;
    logic [4:0]      debug_wb_rf_waddr = '0;
    logic [XLEN-1:0] debug_wb_rf_wdata = '0;
    logic            trace_en = 1'b0;
    logic            clr_ovf = 1'b0;
    logic            trace_valid;
    logic            trace_ready = 1'b0;
    logic [EW-1:0]   trace_data;
    logic [CW-1:0]   trace_count;
    logic            trace_ovf;
    logic [15:0]     ovf_cnt;

    logic [EW-1:0]   exp_q[$];
    int              vectors = 0;
    int              miscompares = 0;
    logic [15:0]     seq_model = 16'd0;

    wb_trace_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk               (clk),
        .reset             (reset),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_waddr (debug_wb_rf_waddr),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
        .trace_en          (trace_en),
        .clr_ovf           (clr_ovf),
        .trace_valid       (trace_valid),
        .trace_ready       (trace_ready),
        .trace_data        (trace_data),
        .trace_count       (trace_count),
        .trace_ovf         (trace_ovf),
        .ovf_cnt           (ovf_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: a beat is consumed at the next rising edge when valid && ready
    always @(negedge clk) begin
        if (trace_valid && trace_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL beat: got %h, expected no entry", trace_data);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                if (trace_data !== e) begin
                    miscompares++;
                    $display("FAIL beat: got %h, expected %h", trace_data, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [EW-1:0] mk(input logic [15:0] s, input logic [3:0] we,
                                         input logic [4:0] wa, input logic [31:0] pc,
                                         input logic [31:0] wd);
`ifdef WB_TRACE_SEQ_EN
        return {s, we, wa, pc, wd};
`else
        return {we, wa, pc, wd};
`endif
    endfunction

    // Present one capture event for vector index i; queue it if expected to be stored
    task automatic wr(input int i, input bit stored);
        debug_wb_pc       = 32'h8000_0000 + 32'(i * 4);
        debug_wb_rf_we    = (i % 2 == 1) ? 4'h3 : 4'hF;
        debug_wb_rf_waddr = 5'((i % 31) + 1);
        debug_wb_rf_wdata = 32'hA5A5_0000 + 32'(i);
        trace_en          = 1'b1;
        if (stored) begin
            exp_q.push_back(mk(seq_model, debug_wb_rf_we, debug_wb_rf_waddr,
                               debug_wb_pc, debug_wb_rf_wdata));
        end
        seq_model = seq_model + 16'd1;
    endtask

    task automatic idle();
        debug_wb_rf_we    = 4'h0;
        debug_wb_rf_waddr = 5'd0;
        trace_en          = 1'b0;
        clr_ovf           = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (trace_count != 0 && n < 40) begin
            cyc();
            n++;
        end
        chk(name, 32'(trace_count), 32'd0);
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_valid", 32'(trace_valid), 32'd0);
        chk("rst_count", 32'(trace_count), 32'd0);
        chk("rst_ovf",   32'(trace_ovf),   32'd0);
        chk("rst_ovfcnt", 32'(ovf_cnt),    32'd0);
        chk("rst_data_lo", trace_data[31:0], 32'd0);
        cyc();
        reset = 1'b1;
        cyc();

        // Basic capture
        trace_ready       = 1'b1;
        debug_wb_pc       = 32'hBFC0_0000;
        debug_wb_rf_we    = 4'hF;
        debug_wb_rf_waddr = 5'd8;
        debug_wb_rf_wdata = 32'h1234_5678;
        trace_en          = 1'b1;
        exp_q.push_back(mk(16'd0, 4'hF, 5'd8, 32'hBFC0_0000, 32'h1234_5678));
        seq_model = 16'd1;
        cyc();
        idle();
        chk("basic_valid", 32'(trace_valid), 32'd1);
        chk("basic_count", 32'(trace_count), 32'd1);
        cyc();
        chk("basic_count_after", 32'(trace_count), 32'd0);
        chk("basic_valid_after", 32'(trace_valid), 32'd0);

        // Filtering: waddr=0, we=0, trace_en=0
        trace_en = 1'b1; debug_wb_rf_we = 4'hF; debug_wb_rf_waddr = 5'd0;
        cyc();
        chk("filt_waddr0", 32'({trace_valid, trace_count}), 32'd0);
        debug_wb_rf_we = 4'h0; debug_wb_rf_waddr = 5'd3;
        cyc();
        chk("filt_we0", 32'({trace_valid, trace_count}), 32'd0);
        trace_en = 1'b0; debug_wb_rf_we = 4'hF;
        cyc();
        chk("filt_en0", 32'({trace_valid, trace_count}), 32'd0);
        idle();

        // Fill and overflow
        trace_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            wr(i, i < DEPTH);
            cyc();
        end
        chk("fill_count", 32'(trace_count), 32'd16);
        chk("fill_ovf",   32'(trace_ovf),   32'd1);
        chk("fill_ovfcnt", 32'(ovf_cnt),    32'd4);

        // Full with simultaneous push and pop
        trace_ready = 1'b1;
        wr(20, 1'b1);
        cyc();
        idle();
        chk("pp_count",  32'(trace_count), 32'd16);
        chk("pp_ovfcnt", 32'(ovf_cnt),     32'd4);
        drain("pp_drain");
        chk("pp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Clear priority over a coincident drop
        trace_ready = 1'b0;
        for (int i = 100; i < 116; i++) begin
            wr(i, 1'b1);
            cyc();
        end
        wr(116, 1'b0);
        clr_ovf = 1'b1;
        cyc();
        idle();
        chk("clr_ovf",    32'(trace_ovf), 32'd0);
        chk("clr_ovfcnt", 32'(ovf_cnt),   32'd0);
        wr(117, 1'b0);
        cyc();
        idle();
        chk("drop_ovf",    32'(trace_ovf), 32'd1);
        chk("drop_ovfcnt", 32'(ovf_cnt),   32'd1);

        // Asynchronous reset mid-drain with five entries queued
        trace_ready = 1'b1;
        repeat (11) cyc();
        chk("middrain_count", 32'(trace_count), 32'd5);
        #1;
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("areset_valid", 32'(trace_valid), 32'd0);
        chk("areset_count", 32'(trace_count), 32'd0);
        chk("areset_ovf",   32'(trace_ovf),   32'd0);
        trace_ready = 1'b0;
        cyc();
        reset = 1'b1;
        seq_model = 16'd0;
        cyc();

        // Sequence numbering: 18 events, 16 stored, then one more accepted
        for (int i = 200; i < 218; i++) begin
            wr(i, i < 216);
            cyc();
        end
        idle();
        chk("seq_fill_ovfcnt", 32'(ovf_cnt), 32'd2);
        trace_ready = 1'b1;
        drain("seq_drain");
        wr(218, 1'b1);
        cyc();
        idle();
        drain("seq_last_drain");
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_trace_buffer.md
Name: wb_trace_buffer

Overview:
- Sits directly downstream of the pipeline core's write-back debug port (debug_wb_pc / debug_wb_rf_we / debug_wb_rf_waddr / debug_wb_rf_wdata).
- Captures each retiring register write into a FIFO.
- Drains entries over a valid/ready stream to a trace sink (UART packer, sim checker, or logic analyser).
- Counts entries dropped when full, so a test harness can compare against a golden trace without stalling the core. The core has no stall input.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- XLEN, 32, data/PC width; matches the core.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- debug_wb_pc  input  XLEN  PC of the retiring instruction.
- debug_wb_rf_we  input  4  byte write enables from write-back.
- debug_wb_rf_waddr  input  5  destination register.
- debug_wb_rf_wdata  input  XLEN  write data.
- trace_en  input  1  capture enable; level-sensitive.
- clr_ovf  input  1  one-cycle pulse; clears the overflow flag and counter.
- trace_valid  output  1  head entry available.
- trace_ready  input  1  sink accepts the head entry.
- trace_data  output  ENTRY_WD  packed entry {we[3:0], waddr[4:0], pc[XLEN-1:0], wdata[XLEN-1:0]}; 73 bits by default.
- trace_count  output  $clog2(DEPTH)+1  current occupancy.
- trace_ovf  output  1  sticky: at least one entry dropped.
- ovf_cnt  output  16  dropped-entry count, saturating.

Behaviour:
- Reset (reset low, asynchronous): FIFO empty, rd/wr pointers 0, trace_valid=0, trace_data=0, trace_count=0, trace_ovf=0, ovf_cnt=0.
- Capture event: trace_en=1, |debug_wb_rf_we=1, debug_wb_rf_waddr!=0. Sampled on every rising clk; one event per cycle at most.
- Push: on a capture event, the entry is written at wr_ptr if not full, or if full and a pop occurs in the same cycle (pop frees a slot first).
- Dropped event: capture event while full with no pop. Nothing is written; trace_ovf<=1; ovf_cnt increments, saturating at 16'hFFFF.
- Pop: trace_valid && trace_ready. Advances rd_ptr.
- Output timing: first-word-fall-through. An entry pushed in cycle N is visible on trace_valid/trace_data in cycle N+1 if the FIFO was empty.
- Stability: trace_data and trace_valid hold stable while trace_valid && !trace_ready.
- Pointers: $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty. Wrap-around is modulo 2*DEPTH.
- trace_count is registered: +1 on push only, -1 on pop only, unchanged on push+pop or neither. Full = (trace_count==DEPTH).
- Push+pop in the same cycle when empty: the pop is not possible (trace_valid=0); push only.
- clr_ovf coincident with a dropped event: clear wins, so trace_ovf=0 and ovf_cnt=0 that cycle.
- trace_en deassertion: does not flush; queued entries keep draining.
- Reset mid-drain: all queued entries are discarded immediately and asynchronously.
- No combinational path from the debug_wb_* inputs to any output.

Optional Feature:
- Macro: WB_TRACE_SEQ_EN.
- Defined:
  - A 16-bit sequence counter increments on every capture event, including dropped ones, and wraps at 16'hFFFF->0.
  - The counter value is prepended to the entry: {seq[15:0], we, waddr, pc, wdata}, so ENTRY_WD=89. Gaps in seq expose drops.
  - The counter resets to 0.
- Undefined: no counter; ENTRY_WD=73.

Decomposition:
- Shared package/header (cpu.vh style):
  - TRACE_ENTRY_WD (conditional on WB_TRACE_SEQ_EN).
  - Field offsets TRACE_WDATA_LSB, TRACE_PC_LSB, TRACE_WADDR_LSB, TRACE_WE_LSB, TRACE_SEQ_LSB.
  - TRACE_OVF_CNT_WD=16.
- Sub-module trace_fifo: generic synchronous FWFT FIFO with WIDTH and DEPTH parameters, push/pop/full/empty/count.
- Capture qualification, overflow tracking and sequence numbering stay in wb_trace_buffer.

Test Plan:
- Basic capture: one write with pc=0xBFC00000, we=4'hF, waddr=5'd8, wdata=0x12345678, ready=1 -> trace_valid high the next cycle, trace_data={4'hF, 5'd8, 0xBFC00000, 0x12345678}, trace_count returns to 0.
- Filtering: writes with waddr=0, we=0, or trace_en=0 -> trace_valid stays 0 and trace_count=0.
- Fill and overflow: ready=0, 20 consecutive valid writes, DEPTH=16 -> trace_count=16, trace_ovf=1, ovf_cnt=4. Drain yields the first 16 entries in order.
- Full with simultaneous push+pop: FIFO full, ready=1, capture event -> no drop, ovf_cnt unchanged, trace_count stays 16.
- Clear priority and async reset: clr_ovf in the same cycle as a drop -> ovf_cnt=0, trace_ovf=0. Assert reset mid-drain with 5 entries -> trace_valid=0 and trace_count=0 without waiting for a clk edge.
- WB_TRACE_SEQ_EN: 18 events into DEPTH=16 with ready=0, then drain -> seq fields 0..15 seen. The next accepted event carries seq=18.
